// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered SEL_W-to-OUT_W one-hot decoder with enable and an
// autonomous scan sequencer that walks the active output through every code,
// holding each code for (dwell+1) enabled cycles.
// Optional build macro DEC_SEQ_ONEHOT_CHK_EN adds a sticky o_err flag that is
// set when the registered decode is non-zero but not one-hot.
// Handshake: i_start is a level sampled only in IDLE; it is accepted on a rising
// clock edge where i_start=1, i_en=1 and i_stop=0. i_stop aborts a scan on the
// next edge and always wins over i_start. o_done is a single-cycle pulse.
module decoder_scan_seq #(
   parameter int SEL_W   = 3,
   parameter int OUT_W   = 1 << SEL_W,
   parameter int DWELL_W = 4,
   parameter bit REV     = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [SEL_W-1:0]   i_sel,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_cont,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic [OUT_W-1:0]   o_d,
   output logic [SEL_W-1:0]   o_code,
   output logic               o_busy,
   output logic               o_done,
`ifdef DEC_SEQ_ONEHOT_CHK_EN
   output logic               o_err,
`endif
   output logic [1:0]         o_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of codes visited in a single pass (fits in SEL_W+1 bits).
   localparam logic [SEL_W:0] LP_LAST = OUT_W[SEL_W:0];

   state_t             r_state;
   logic [OUT_W-1:0]   r_d;
   logic [SEL_W-1:0]   r_code;
   logic               r_busy;
   logic               r_done;
   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_cont;
   logic [SEL_W:0]     r_visited;

   state_t             w_state_nxt;
   logic [OUT_W-1:0]   w_d_nxt;
   logic [SEL_W-1:0]   w_code_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic [DWELL_W-1:0] w_dwell_nxt;
   logic               w_cont_nxt;
   logic [SEL_W:0]     w_visited_nxt;
   logic               w_accept;
   logic [SEL_W-1:0]   w_code_inc;

   // Legacy bit map: with REV, code k lights d[OUT_W-1-k], which is index ~k.
   function automatic logic [OUT_W-1:0] f_onehot(input logic [SEL_W-1:0] k);
      logic [SEL_W-1:0] idx;
      idx = REV ? ~k : k;
      return {{(OUT_W-1){1'b0}}, 1'b1} << idx;
   endfunction

   assign w_code_inc = r_code + SEL_W'(1);

   // Next-state and next-output decode for the IDLE/SCAN/DONE sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_d_nxt       = '0;
      w_code_nxt    = r_code;
      w_cnt_nxt     = r_cnt;
      w_dwell_nxt   = r_dwell;
      w_cont_nxt    = r_cont;
      w_visited_nxt = r_visited;
      w_accept      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_d_nxt    = i_en ? f_onehot(i_sel) : '0;
            w_code_nxt = i_sel;
            if (i_start && i_en && !i_stop) begin
               w_accept      = 1'b1;
               w_state_nxt   = ST_SCAN;
               w_cnt_nxt     = '0;
               w_dwell_nxt   = i_dwell;
               w_cont_nxt    = i_cont;
               w_visited_nxt = (SEL_W+1)'(1);
            end
         end
         ST_SCAN: begin
            if (i_stop) begin
               w_state_nxt = ST_IDLE;
               w_d_nxt     = i_en ? f_onehot(i_sel) : '0;
               w_code_nxt  = i_sel;
            end else if (!i_en) begin
               // Paused: outputs blank, position frozen.
               w_d_nxt = '0;
            end else if (r_cnt == r_dwell) begin
               if (!r_cont && (r_visited == LP_LAST)) begin
                  w_state_nxt = ST_DONE;
                  w_d_nxt     = '0;
               end else begin
                  w_cnt_nxt     = '0;
                  w_code_nxt    = w_code_inc;
                  w_d_nxt       = f_onehot(w_code_inc);
                  w_visited_nxt = r_cont ? r_visited : r_visited + (SEL_W+1)'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + DWELL_W'(1);
               w_d_nxt   = f_onehot(r_code);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_d_nxt     = i_en ? f_onehot(i_sel) : '0;
            w_code_nxt  = i_sel;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; busy/done are decoded from the next state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_d       <= '0;
         r_code    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cnt     <= '0;
         r_dwell   <= '0;
         r_cont    <= 1'b0;
         r_visited <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_d       <= w_d_nxt;
         r_code    <= w_code_nxt;
         r_busy    <= (w_state_nxt == ST_SCAN);
         r_done    <= (w_state_nxt == ST_DONE);
         r_cnt     <= w_cnt_nxt;
         r_dwell   <= w_dwell_nxt;
         r_cont    <= w_cont_nxt;
         r_visited <= w_visited_nxt;
      end
   end

`ifdef DEC_SEQ_ONEHOT_CHK_EN
   logic r_err;

   // Sticky flag for a multi-hot decode; an accepted start clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end else if ((r_d != '0) && ((r_d & (r_d - OUT_W'(1))) != '0)) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`endif

   assign o_d     = r_d;
   assign o_code  = r_code;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_state = r_state;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// tb_decoder_scan_seq: directed and randomized bench for decoder_scan_seq.
// A reference model expressed as "enabled cycles elapsed since start" predicts
// each cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_decoder_scan_seq;
   localparam int SEL_W   = 3;
   localparam int OUT_W   = 8;
   localparam int DWELL_W = 4;
   localparam bit REV     = 1'b1;
   localparam int W       = OUT_W + SEL_W + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic               en, start, stop, cont;
   logic [SEL_W-1:0]   sel;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   d;
   logic [SEL_W-1:0]   code;
   logic               busy, done;
   logic [1:0]         state;
`ifdef DEC_SEQ_ONEHOT_CHK_EN
   logic               err;
   logic               b_err;
`endif

   // second instance: REV=0, SEL_W=2
   logic       b_en;
   logic [1:0] b_sel;
   logic [3:0] b_d;
   logic [1:0] b_code;
   logic       b_busy, b_done;
   logic [1:0] b_state;

   decoder_scan_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .REV(REV)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel), .i_start(start),
      .i_stop(stop), .i_cont(cont), .i_dwell(dwell), .o_d(d), .o_code(code),
      .o_busy(busy), .o_done(done),
`ifdef DEC_SEQ_ONEHOT_CHK_EN
      .o_err(err),
`endif
      .o_state(state)
   );

   decoder_scan_seq #(.SEL_W(2), .DWELL_W(DWELL_W), .REV(1'b0)) u_dut_rev0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_sel(b_sel), .i_start(1'b0),
      .i_stop(1'b0), .i_cont(1'b0), .i_dwell(4'd0), .o_d(b_d), .o_code(b_code),
      .o_busy(b_busy), .o_done(b_done),
`ifdef DEC_SEQ_ONEHOT_CHK_EN
      .o_err(b_err),
`endif
      .o_state(b_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode 0 idle, 1 scanning, 2 done pulse; t counts enabled scan cycles.
   int m_mode = 0;
   int m_t    = 0;
   int m_s    = 0;
   int m_dw   = 0;
   bit m_cont = 1'b0;

   function automatic logic [OUT_W-1:0] ref_onehot(input int k);
      logic [OUT_W-1:0] v;
      v = '0;
      v[REV ? (OUT_W - 1 - k) : k] = 1'b1;
      return v;
   endfunction

   function automatic int scan_code(input int t);
      return (m_s + t / (m_dw + 1)) % OUT_W;
   endfunction

   task automatic model_step();
      logic [OUT_W-1:0] ed;
      int ec;
      bit eb, edn;
      eb  = 1'b0;
      edn = 1'b0;
      ec  = int'(sel);
      ed  = en ? ref_onehot(int'(sel)) : '0;
      case (m_mode)
         0: begin
            if (start && en && !stop) begin
               m_mode = 1; m_t = 0; m_s = int'(sel); m_dw = int'(dwell); m_cont = cont;
               eb = 1'b1;
            end
         end
         1: begin
            if (stop) begin
               m_mode = 0;
            end else if (!en) begin
               ed = '0; ec = scan_code(m_t); eb = 1'b1;
            end else begin
               m_t++;
               if (!m_cont && m_t == OUT_W * (m_dw + 1)) begin
                  m_mode = 2; ed = '0; ec = scan_code(m_t - 1); edn = 1'b1;
               end else begin
                  ec = scan_code(m_t); ed = ref_onehot(ec); eb = 1'b1;
               end
            end
         end
         default: m_mode = 0;
      endcase
      exp_q.push_back({ed, ec[SEL_W-1:0], eb, edn});
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if ({d, code, busy, done} !== e) begin
            n_errors++;
            $display("FAIL scoreboard t=%0t: d=%h code=%0d busy=%b done=%b, expected d=%h code=%0d busy=%b done=%b",
                     $time, d, code, busy, done, e[W-1 -: OUT_W], e[SEL_W+1:2], e[1], e[0]);
         end
`ifdef DEC_SEQ_ONEHOT_CHK_EN
         n_checks++;
         if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_flag t=%0t: got %b expected 0", $time, err);
         end
`endif
      end
   end

   // Single pass from sel s with dwell dw; optional 3-cycle pause at code 7.
   task automatic run_single(input string name, input int s, input int dw,
                             input bit pause, input int exp_busy);
      int nb, pause_left;
      bit seen, paused;
      nb = 0; pause_left = 0; seen = 1'b0; paused = 1'b0;
      en = 1'b1; sel = s[SEL_W-1:0]; dwell = dw[DWELL_W-1:0]; cont = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
            check({name, "_done_d"}, d, 0);
            check({name, "_done_busy"}, busy, 0);
         end else begin
            if (busy) nb++;
            if (pause && !paused && busy && code == 3'd7) begin
               paused = 1'b1; pause_left = 3;
            end
            en = (pause_left > 0) ? 1'b0 : 1'b1;
            if (pause_left > 0) pause_left--;
            sel = SEL_W'($urandom_range(0, OUT_W - 1));
            step();
         end
      end
      check({name, "_done_seen"}, seen, 1);
      check({name, "_busy_cycles"}, nb, exp_busy);
      step();
      check({name, "_done_one_cycle"}, done, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int wraps, prev;
      bit any_done;
      rst_n = 1'b0; en = 1'b0; sel = '0; start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = '0;
      b_en = 1'b1; b_sel = 2'd1;
      #12;
      check("reset_d", d, 0);
      check("reset_code", code, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_state", state, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // direct decode
      en = 1'b1; sel = 3'd0;
      step();
      check("t1_sel0", d, 32'h80);
      check("rev0_sel1", b_d, 4'b0010);
      sel = 3'd5; b_sel = 2'd3;
      step();
      check("t1_sel5", d, 32'h04);
      check("rev0_sel3", b_d, 4'b1000);
      en = 1'b0; b_sel = 2'd0;
      step();
      check("t1_en0", d, 0);
      check("rev0_sel0", b_d, 4'b0001);

      // single pass, pause, max dwell
      run_single("t2", 6, 1, 1'b0, 16);
      run_single("t3", 6, 1, 1'b1, 19);
      run_single("tmax", 0, 15, 1'b0, 128);

      // continuous + stop
      en = 1'b1; cont = 1'b1; dwell = '0; sel = '0; start = 1'b1;
      step();
      start = 1'b0;
      wraps = 0; prev = int'(code); any_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         any_done |= done;
         if (code == 3'd0 && prev == 7) wraps++;
         prev = int'(code);
         if (wraps >= 2 && code == 3'd3) break;
      end
      check("t4_wraps", wraps, 2);
      check("t4_code3", code, 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t4_stop_busy", busy, 0);
      check("t4_stop_done", done | any_done, 0);
      check("t4_stop_state", state, 0);

      // start & stop together, then reset mid-scan
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("t5_prio_busy", busy, 0);
      cont = 1'b1; dwell = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("t5_busy_before_rst", busy, 1);
      #2;
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check("t5_rst_d", d, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_code", code, 0);
      check("t5_rst_state", state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_mode = 0; m_t = 0;

      // randomized phase
      repeat (1500) begin
         en    = ($urandom_range(0, 9) != 0);
         sel   = SEL_W'($urandom_range(0, OUT_W - 1));
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 39) == 0);
         cont  = ($urandom_range(0, 3) == 0);
         dwell = ($urandom_range(0, 9) == 0) ? 4'd15 : DWELL_W'($urandom_range(0, 2));
         step();
      end
      en = 1'b0; start = 1'b0; stop = 1'b0;
      step();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
